deserializer: RTL and testbench
===============================

# deserializer

Serial-to-parallel front end of the receive path. It assembles one bit per `write_in` strobe into 8-bit words and offers each completed word to the 8-entry queue with a one-cycle `data_ready_out` pulse. It then waits for the queue's `ack_in` or `full_in` response, and re-offers the word when the queue is full or no response arrives. Runs entirely in the `clock_10k` domain.

## Interface
- `MSB_FIRST`, default 1: 1 = first received bit lands in `data_out[7]`; 0 = first bit lands in `data_out[0]`.
- `ACK_TIMEOUT`, default 15: WAIT-state cycles without any queue response before the word is re-offered; legal range 1..255.

Ports:
- `clock_10k`  in  1  system clock, 10 kHz; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `data_in`  in  1  serial data bit, sampled only when `write_in`=1.
- `write_in`  in  1  bit-valid strobe, one bit per high cycle.
- `ack_in`  in  1  queue accepted the word (queue `ack_in_q`).
- `full_in`  in  1  queue rejected the word as full (queue `status_out`).
- `data_out`  out  8  last completed word.
- `data_ready_out`  out  1  enqueue request (drives queue `enq_in`).
- `status_out`  out  1  1 = accepting serial bits (COLLECT state).
- `overrun_out`  out  1  sticky: a bit arrived while not accepting.

## Operation
- States: COLLECT, ISSUE, WAIT. Reset state is COLLECT.
- Reset values: `data_out`=0x00, `data_ready_out`=0, `status_out`=1, `overrun_out`=0. Bit counter, shift register and timeout counter are all 0.
- COLLECT:
  - On `write_in`=1, shift `data_in` into the shift register and increment the 3-bit bit counter.
  - On the 8th bit (counter==7), load the completed word into `data_out`, reset the counter to 0, and go to ISSUE.
  - With `MSB_FIRST`=1, the register shifts left and the new bit enters at bit 0. With `MSB_FIRST`=0, it shifts right and the new bit enters at bit 7.
- ISSUE:
  - `data_ready_out`=1 for exactly one cycle.
  - Clear the timeout counter and go to WAIT unconditionally.
- WAIT (`data_ready_out`=0):
  - `ack_in`=1: go to COLLECT.
  - Else `full_in`=1: go to ISSUE (re-offer the same word).
  - Else increment the timeout counter. When it reaches `ACK_TIMEOUT`, go to ISSUE.
  - `ack_in` and `full_in` both high: `ack_in` wins.
- `write_in`=1 in ISSUE or WAIT: the bit is discarded and `overrun_out` is set. `overrun_out` clears only on reset.
- `data_out` changes only when a word completes. It holds its value through ISSUE, WAIT and every retry, and stays valid after return to COLLECT.
- `ack_in`/`full_in` while in COLLECT or ISSUE: ignored.
- Reset mid-operation:
  - Any partial word, pending word or retry is dropped.
  - Outputs return to their reset values.
  - The next bit after reset is bit 0 of a new word.

## Timing
- Last bit sampled at edge N: `data_out` is updated and `data_ready_out`=1 after N. `status_out`=0 after N.
- The queue samples `data_ready_out` at N+1 and returns `ack_in` after N+1.
- The deserializer samples `ack_in` at N+2. `status_out`=1 after N+2, so the first bit of the next word is accepted at N+3.
- Bits strobed at N+1 or N+2 are overruns.
- Full case: `full_in` is seen at N+2, and `data_ready_out` pulses again after N+2. Retry period is 2 cycles while the queue stays full.
- Timeout case: with no response, the re-offer pulse follows `ACK_TIMEOUT`+1 cycles after the previous pulse.
- `data_ready_out` is never high on two consecutive cycles, so one offer cannot be enqueued twice.
- Minimum word period: 8 bit cycles + 2 handshake cycles.

## Test plan
1. Reset asserted → `data_out`=0x00, `data_ready_out`=0, `status_out`=1, `overrun_out`=0. Repeat with reset asynchronous mid-cycle.
2. `MSB_FIRST`=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles, `ack_in` returned one cycle after the pulse → `data_out`=0xA5 and a single 1-cycle `data_ready_out` pulse; `status_out` is 0 for 2 cycles, then 1. Repeat with `MSB_FIRST`=0 → `data_out`=0xA5 requires bits 1,0,1,0,0,1,0,1 LSB first.
3. Word 0x3C with `full_in` returned for 3 offers, then `ack_in` → 4 `data_ready_out` pulses spaced 2 cycles apart, `data_out` stable at 0x3C throughout, then COLLECT.
4. Word 0x81 with no response, `ACK_TIMEOUT`=15 → re-offer pulses every 16 cycles; `ack_in` then returns to COLLECT.
5. `write_in` pulsed during WAIT → `overrun_out`=1 and the next word is unaffected. `ack_in`+`full_in` together → treated as ack.
6. Reset after 5 bits, then bits of 0xC3 → exactly one word, 0xC3; no stale bits carried over.

Source files
------------

// File: rtl/deserializer.sv
// Serial-to-parallel receive front end: collects 8 bits per word, offers each
// word to the downstream queue and re-offers it on full or on response timeout.
module deserializer #(
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clock_10k,
  input  logic       reset,
  input  logic       data_in,
  input  logic       write_in,
  input  logic       ack_in,
  input  logic       full_in,
  output logic [7:0] data_out,
  output logic       data_ready_out,
  output logic       status_out,
  output logic       overrun_out,
  output logic [1:0] dbg_state_out
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(ACK_TIMEOUT);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic [7:0] tmo_q, tmo_d;
  logic       overrun_q, overrun_d;

  logic [7:0] shifted;
  logic [7:0] tmo_inc;

  // Handshake: data_ready_out is a single-cycle enqueue request; the queue
  // answers one cycle later with ack_in (accepted) or full_in (rejected).
  // ack_in has priority; with neither, the word is re-offered after
  // ACK_TIMEOUT idle cycles in WAIT.

  always_ff @(posedge clock_10k or posedge reset) begin
    if (reset) begin
      state_q   <= COLLECT;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      tmo_q     <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_inc = tmo_q + 8'd1;
    unique case (state_q)
      COLLECT: if (write_in && bit_cnt_q == 3'd7) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (ack_in)                  state_d = COLLECT;
        else if (full_in)            state_d = ISSUE;
        else if (tmo_inc == TMO_LIMIT) state_d = ISSUE;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    overrun_d = overrun_q;
    if (MSB_FIRST) shifted = {shift_q[6:0], data_in};
    else           shifted = {data_in, shift_q[7:1]};

    case (state_q)
      COLLECT: begin
        if (write_in) begin
          shift_d   = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) data_d = shifted;
        end
      end
      ISSUE: tmo_d = 8'h00;
      WAIT:  if (!ack_in && !full_in) tmo_d = tmo_q + 8'd1;
      default: ;
    endcase

    // Bits arriving while a word is pending are dropped, not buffered.
    if (write_in && state_q != COLLECT) overrun_d = 1'b1;
  end

  always_comb begin
    data_out       = data_q;
    data_ready_out = (state_q == ISSUE);
    status_out     = (state_q == COLLECT);
    overrun_out    = overrun_q;
    dbg_state_out  = state_q;
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: an MSB-first and an LSB-first instance
// share all stimulus, so each word yields the bit-reversed value on the latter.
`timescale 1us/1ns
module tb_deserializer;

  logic       clock_10k;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       ack_in;
  logic       full_in;

  logic [7:0] m_data, l_data;
  logic       m_ready, l_ready;
  logic       m_status, l_status;
  logic       m_overrun, l_overrun;
  logic [1:0] m_state, l_state;

  int check_cnt = 0;
  int pass_cnt  = 0;

  deserializer #(.MSB_FIRST(1'b1), .ACK_TIMEOUT(15)) u_msb (
    .clock_10k      (clock_10k),
    .reset          (reset),
    .data_in        (data_in),
    .write_in       (write_in),
    .ack_in         (ack_in),
    .full_in        (full_in),
    .data_out       (m_data),
    .data_ready_out (m_ready),
    .status_out     (m_status),
    .overrun_out    (m_overrun),
    .dbg_state_out  (m_state)
  );

  deserializer #(.MSB_FIRST(1'b0), .ACK_TIMEOUT(15)) u_lsb (
    .clock_10k      (clock_10k),
    .reset          (reset),
    .data_in        (data_in),
    .write_in       (write_in),
    .ack_in         (ack_in),
    .full_in        (full_in),
    .data_out       (l_data),
    .data_ready_out (l_ready),
    .status_out     (l_status),
    .overrun_out    (l_overrun),
    .dbg_state_out  (l_state)
  );

  // clock / reset
  initial clock_10k = 1'b0;
  always #50 clock_10k = ~clock_10k;

  task automatic tick();
    @(posedge clock_10k);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  // Driver: eight bits MSB of w first; returns just after the completing edge.
  task automatic send_word(input logic [7:0] w, input logic [7:0] exp_lsb);
    for (int i = 0; i < 8; i++) begin
      data_in  = w[3'(7 - i)];
      write_in = 1'b1;
      tick();
    end
    write_in = 1'b0;
    data_in  = 1'b0;
    chk8("word_msb", m_data, w);
    chk8("word_lsb", l_data, exp_lsb);
    chk1("pulse_on", m_ready, 1'b1);
    chk1("status_busy", m_status, 1'b0);
    chk8("state_issue", {6'd0, m_state}, 8'd1);
  endtask

  // Queue answers ack one cycle after the pulse.
  task automatic ack_handshake();
    tick();
    chk1("pulse_off", m_ready, 1'b0);
    chk1("status_wait", m_status, 1'b0);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk1("status_back", m_status, 1'b1);
    chk1("no_pulse_after_ack", m_ready, 1'b0);
  endtask

  initial begin
    int hi;
    reset    = 1'b1;
    data_in  = 1'b0;
    write_in = 1'b0;
    ack_in   = 1'b0;
    full_in  = 1'b0;
    tick();
    tick();

    // reset values
    chk8("rst_data", m_data, 8'h00);
    chk1("rst_ready", m_ready, 1'b0);
    chk1("rst_status", m_status, 1'b1);
    chk1("rst_overrun", m_overrun, 1'b0);
    reset = 1'b0;
    tick();

    // 0xA5 (palindrome: same value for either bit order), ack one cycle later
    send_word(8'hA5, 8'hA5);
    ack_handshake();

    // 0x3C rejected full three times, then acked
    send_word(8'h3C, 8'h3C);
    for (int r = 0; r < 3; r++) begin
      tick();
      chk1("full_gap", m_ready, 1'b0);
      full_in = 1'b1;
      tick();
      full_in = 1'b0;
      chk1("full_reoffer", m_ready, 1'b1);
      chk8("full_hold", m_data, 8'h3C);
    end
    ack_handshake();

    // 0x81 with no response: re-offer 16 cycles after the first pulse
    send_word(8'h81, 8'h81);
    hi = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      hi += int'(m_ready);
    end
    chk8("tmo_quiet", 8'(hi), 8'd0);
    chk8("state_wait", {6'd0, m_state}, 8'd2);
    tick();
    chk1("tmo_reoffer", m_ready, 1'b1);
    chk8("tmo_hold", m_data, 8'h81);
    ack_handshake();

    // overrun during WAIT, then ack+full together counts as ack
    send_word(8'h55, 8'hAA);
    tick();
    data_in  = 1'b1;
    write_in = 1'b1;
    tick();
    write_in = 1'b0;
    data_in  = 1'b0;
    chk1("overrun_set", m_overrun, 1'b1);
    chk1("overrun_lsb", l_overrun, 1'b1);
    ack_in  = 1'b1;
    full_in = 1'b1;
    tick();
    ack_in  = 1'b0;
    full_in = 1'b0;
    chk1("ack_wins_status", m_status, 1'b1);
    chk1("ack_wins_pulse", m_ready, 1'b0);
    send_word(8'h12, 8'h48);
    chk1("overrun_sticky", m_overrun, 1'b1);
    ack_handshake();

    // partial word, asynchronous reset mid-cycle, then a clean 0xC3
    for (int i = 0; i < 5; i++) begin
      data_in  = 1'b1;
      write_in = 1'b1;
      tick();
    end
    write_in = 1'b0;
    data_in  = 1'b0;
    #25;
    reset = 1'b1;
    #1;
    chk8("async_rst_data", m_data, 8'h00);
    chk1("async_rst_overrun", m_overrun, 1'b0);
    chk1("async_rst_status", m_status, 1'b1);
    chk1("async_rst_ready", m_ready, 1'b0);
    #10;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      data_in  = (i < 2 || i > 5) ? 1'b1 : 1'b0;
      write_in = 1'b1;
      tick();
    end
    write_in = 1'b0;
    chk1("no_stale_word", m_ready, 1'b0);
    chk1("still_collect", m_status, 1'b1);
    data_in  = 1'b1;
    write_in = 1'b1;
    tick();
    write_in = 1'b0;
    data_in  = 1'b0;
    chk8("clean_word", m_data, 8'hC3);
    chk1("clean_pulse", m_ready, 1'b1);
    ack_handshake();
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      hi += int'(m_ready);
    end
    chk8("single_word", 8'(hi), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
